// File: rtl/rob_wb_notify.sv
// Writeback-completion notifier: buffers per-unit completion reports in age order and
// drives the ROB's four busy-clear ports from the oldest queued entries.
module rob_wb_notify #(
    parameter int WIDTH_BANK = 3,
    parameter int WIDTH_BRM  = 4,
    parameter int NUM_EU     = 6,
    parameter int DEPTH      = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_EU-1:0]                i_wb_valid,
    input  logic [NUM_EU*(WIDTH_BANK+2)-1:0] i_wb_tag,
    input  logic [NUM_EU*WIDTH_BRM-1:0]      i_wb_brm,
    input  logic [WIDTH_BRM:0]               i_kill,
    output logic                             o_wb_ready,
    output logic [2+WIDTH_BANK:0]            o_rst_busy0,
    output logic [2+WIDTH_BANK:0]            o_rst_busy1,
    output logic [2+WIDTH_BANK:0]            o_rst_busy2,
    output logic [2+WIDTH_BANK:0]            o_rst_busy3
);

    localparam int TW = WIDTH_BANK + 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = 3 + WIDTH_BANK;

    logic                 r_live [DEPTH];
    logic [TW-1:0]        r_tag  [DEPTH];
    logic [WIDTH_BRM-1:0] r_brm  [DEPTH];
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    logic                 r_ready;

    logic [NUM_EU-1:0]    w_acc_valid;
    logic [PW-1:0]        w_wr_idx [NUM_EU];
    logic [CW-1:0]        w_n_acc;
    logic [CW-1:0]        w_pop;
    logic [CW-1:0]        w_next_count;
    logic [CW-1:0]        w_free;
    logic                 w_next_ready;
    logic [OW-1:0]        w_busy [4];

    function automatic logic f_kill_hit(input logic [WIDTH_BRM:0] kill,
                                        input logic [WIDTH_BRM-1:0] brm);
        return kill[WIDTH_BRM] && (kill[WIDTH_BRM-1:0] <= brm);
    endfunction

    assign w_acc_valid = i_wb_valid & {NUM_EU{r_ready}};

    // Compact accepted reports: unit k lands at tail + (number of accepted units below k).
    always_comb begin
        w_n_acc = '0;
        for (int k = 0; k < NUM_EU; k++) begin
            w_wr_idx[k] = r_tail + w_n_acc[PW-1:0];
            if (w_acc_valid[k]) begin
                w_n_acc = w_n_acc + CW'(1);
            end
        end
    end

    always_comb begin
        w_pop        = (r_count >= CW'(4)) ? CW'(4) : r_count;
        w_next_count = r_count + w_n_acc - w_pop;
        w_free       = CW'(DEPTH) - w_next_count;
        w_next_ready = (w_free >= CW'(NUM_EU));
    end

    // The en bit also masks a kill arriving this cycle, so the ROB never sees a killed clear.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_busy[n] = '0;
            if (CW'(n) < r_count) begin
                w_busy[n] = {r_live[r_head + PW'(n)] &
                             ~f_kill_hit(i_kill, r_brm[r_head + PW'(n)]),
                             r_tag[r_head + PW'(n)]};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ready <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                r_live[i] <= 1'b0;
                r_tag[i]  <= '0;
                r_brm[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_live[i] && f_kill_hit(i_kill, r_brm[i])) begin
                    r_live[i] <= 1'b0;
                end
            end
            for (int k = 0; k < NUM_EU; k++) begin
                if (w_acc_valid[k]) begin
                    r_live[w_wr_idx[k]] <= ~f_kill_hit(i_kill, i_wb_brm[k*WIDTH_BRM +: WIDTH_BRM]);
                    r_tag[w_wr_idx[k]]  <= i_wb_tag[k*TW +: TW];
                    r_brm[w_wr_idx[k]]  <= i_wb_brm[k*WIDTH_BRM +: WIDTH_BRM];
                end
            end
            r_head  <= r_head + w_pop[PW-1:0];
            r_tail  <= r_tail + w_n_acc[PW-1:0];
            r_count <= w_next_count;
            r_ready <= w_next_ready;
        end
    end

    assign o_wb_ready  = r_ready;
    assign o_rst_busy0 = w_busy[0];
    assign o_rst_busy1 = w_busy[1];
    assign o_rst_busy2 = w_busy[2];
    assign o_rst_busy3 = w_busy[3];

endmodule
